// File: rtl/nebula_pkg.sv
// nebula_pkg: shared NoC flit format, field widths and flit type codes.
package nebula_pkg;
  localparam int COORD_WIDTH = 4;
  localparam int VC_ID_WIDTH = 2;
  localparam int QOS_WIDTH = 2;
  localparam int SEQ_WIDTH = 8;
  localparam int PKT_ID_WIDTH = 8;
  localparam int NOC_FLIT_PAYLOAD_WIDTH = 64;
  localparam logic [1:0] FLIT_TYPE_HEAD = 2'd0;
  localparam logic [1:0] FLIT_TYPE_BODY = 2'd1;
  localparam logic [1:0] FLIT_TYPE_TAIL = 2'd2;
  localparam logic [1:0] FLIT_TYPE_SINGLE = 2'd3;
  typedef enum logic {IDLE, SEND} asm_state_e;
  typedef struct packed {
    logic [1:0] flit_type;
    logic [COORD_WIDTH-1:0] src_x;
    logic [COORD_WIDTH-1:0] src_y;
    logic [COORD_WIDTH-1:0] dest_x;
    logic [COORD_WIDTH-1:0] dest_y;
    logic [VC_ID_WIDTH-1:0] vc_id;
    logic [QOS_WIDTH-1:0] qos;
    logic [SEQ_WIDTH-1:0] seq_num;
    logic [PKT_ID_WIDTH-1:0] packet_id;
    logic [NOC_FLIT_PAYLOAD_WIDTH-1:0] payload;
  } noc_flit_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction
endpackage

// File: rtl/nebula_rr_arbiter.sv
// nebula_rr_arbiter: round-robin arbiter; grants the first request at or after
// the pointer, which moves past the winner when advance is asserted.
module nebula_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  logic [IW-1:0] ptr_q, ptr_d;
  always_comb begin
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr_q) + i) % N]) grant_idx = IW'((int'(ptr_q) + i) % N);
    grant = |req ? N'(1) << grant_idx : '0;
    ptr_d = advance ? IW'((int'(grant_idx) + 1) % N) : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/nebula_packet_assembler_mc.sv
// nebula_packet_assembler_mc: round-robin accepts whole packets from NUM_CH sources
// and segments each into HEAD/BODY/TAIL or SINGLE flits on one shared output.
module nebula_packet_assembler_mc
  import nebula_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int MAX_PAYLOAD_BYTES = 64,
  parameter int FLIT_PAYLOAD_BITS = NOC_FLIT_PAYLOAD_WIDTH,
  localparam int SW = $clog2(MAX_PAYLOAD_BYTES + 1),
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_CH-1:0]                     pkt_valid,
  output logic [NUM_CH-1:0]                     pkt_ready,
  input  logic [NUM_CH*COORD_WIDTH-1:0]         src_x,
  input  logic [NUM_CH*COORD_WIDTH-1:0]         src_y,
  input  logic [NUM_CH*COORD_WIDTH-1:0]         dest_x,
  input  logic [NUM_CH*COORD_WIDTH-1:0]         dest_y,
  input  logic [NUM_CH*VC_ID_WIDTH-1:0]         vc_id,
  input  logic [NUM_CH*QOS_WIDTH-1:0]           qos,
  input  logic [NUM_CH*MAX_PAYLOAD_BYTES*8-1:0] payload_data,
  input  logic [NUM_CH*SW-1:0]                  payload_size,
  output logic                                  flit_valid,
  output noc_flit_t                             flit_out,
  input  logic                                  flit_ready,
  output logic                                  busy,
  output logic [CW-1:0]                         active_ch,
  output logic                                  size_err,
  output logic [31:0]                           pkts_sent,
  output logic [31:0]                           flits_sent
);
  localparam int MAX_FLITS = (MAX_PAYLOAD_BYTES * 8 + FLIT_PAYLOAD_BITS - 1) / FLIT_PAYLOAD_BITS;
  localparam int FB = FLIT_PAYLOAD_BITS / 8;
  localparam int DW = MAX_FLITS * FLIT_PAYLOAD_BITS;
  localparam int FW = $clog2(MAX_FLITS + 1);
  if (FLIT_PAYLOAD_BITS != NOC_FLIT_PAYLOAD_WIDTH || FLIT_PAYLOAD_BITS % 8 != 0) begin : g_bad_cfg
    $error("FLIT_PAYLOAD_BITS must equal the flit payload width and be a multiple of 8");
  end
  asm_state_e state_q, state_d;
  logic [CW-1:0] ch_q, ch_d, g;
  noc_flit_t hdr_q, hdr_d;
  logic [DW-1:0] data_q, data_d;
  logic [FW-1:0] total_q, total_d, idx_q, idx_d;
  logic [NUM_CH-1:0][SEQ_WIDTH-1:0] seq_q, seq_d;
  logic [PKT_ID_WIDTH-1:0] pid_q, pid_d;
  logic err_q, err_d;
  logic [31:0] pkts_q, pkts_d, flits_q, flits_d;
  logic [NUM_CH-1:0] grant;
  logic accept, fire, last;
  logic [SW-1:0] size_in, eff;
  nebula_rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk, .rst_n, .req(pkt_valid), .advance(accept), .grant, .grant_idx(g)
  );
  assign pkt_ready = state_q == IDLE ? grant : '0;
  assign accept = |pkt_ready;
  assign fire = state_q == SEND && flit_ready;
  assign last = idx_q == total_q - 1'b1;
  assign size_in = payload_size[g*SW +: SW];
  assign eff = size_in > SW'(MAX_PAYLOAD_BYTES) ? SW'(MAX_PAYLOAD_BYTES) : size_in;
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    hdr_d = hdr_q;
    data_d = data_q;
    total_d = total_q;
    idx_d = idx_q;
    seq_d = seq_q;
    pid_d = pid_q;
    err_d = accept && size_in > SW'(MAX_PAYLOAD_BYTES);
    pkts_d = sat_inc(pkts_q, fire && last);
    flits_d = sat_inc(flits_q, fire);
    if (accept) begin
      state_d = SEND;
      ch_d = g;
      idx_d = '0;
      total_d = eff == '0 ? FW'(1) : FW'((int'(eff) + FB - 1) / FB);
      hdr_d = '0;
      hdr_d.src_x = src_x[g*COORD_WIDTH +: COORD_WIDTH];
      hdr_d.src_y = src_y[g*COORD_WIDTH +: COORD_WIDTH];
      hdr_d.dest_x = dest_x[g*COORD_WIDTH +: COORD_WIDTH];
      hdr_d.dest_y = dest_y[g*COORD_WIDTH +: COORD_WIDTH];
      hdr_d.vc_id = vc_id[g*VC_ID_WIDTH +: VC_ID_WIDTH];
      hdr_d.qos = qos[g*QOS_WIDTH +: QOS_WIDTH];
      hdr_d.seq_num = seq_q[g];
      hdr_d.packet_id = pid_q;
      data_d = '0;
      // bytes past the effective size are zeroed so the last flit carries no stale data
      for (int b = 0; b < MAX_PAYLOAD_BYTES; b++)
        data_d[b*8 +: 8] = b < int'(eff) ? payload_data[(int'(g) * MAX_PAYLOAD_BYTES + b) * 8 +: 8] : 8'h00;
    end
    if (fire) begin
      idx_d = idx_q + 1'b1;
      if (last) begin
        state_d = IDLE;
        seq_d[ch_q] = seq_q[ch_q] + 1'b1;
        pid_d = pid_q + 1'b1;
      end
    end
  end
  always_comb begin
    flit_out = '0;
    if (state_q == SEND) begin
      flit_out = hdr_q;
      flit_out.flit_type = total_q == FW'(1) ? FLIT_TYPE_SINGLE :
                           idx_q == '0 ? FLIT_TYPE_HEAD : last ? FLIT_TYPE_TAIL : FLIT_TYPE_BODY;
      flit_out.payload = data_q[idx_q*FLIT_PAYLOAD_BITS +: FLIT_PAYLOAD_BITS];
    end
  end
  assign flit_valid = state_q == SEND;
  assign busy = state_q == SEND;
  assign active_ch = busy ? ch_q : '0;
  assign size_err = err_q;
  assign pkts_sent = pkts_q;
  assign flits_sent = flits_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q <= '0;
      hdr_q <= '0;
      data_q <= '0;
      total_q <= '0;
      idx_q <= '0;
      seq_q <= '0;
      pid_q <= '0;
      err_q <= 1'b0;
      pkts_q <= '0;
      flits_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      hdr_q <= hdr_d;
      data_q <= data_d;
      total_q <= total_d;
      idx_q <= idx_d;
      seq_q <= seq_d;
      pid_q <= pid_d;
      err_q <= err_d;
      pkts_q <= pkts_d;
      flits_q <= flits_d;
    end
endmodule

// File: tb/tb_nebula_packet_assembler_mc.sv
// tb_nebula_packet_assembler_mc: directed and random packets checked against a
// packet-level model that expands each accepted packet into its expected flit list.
module tb_nebula_packet_assembler_mc;
  import nebula_pkg::*;
  localparam int N = 4, MB = 64, SW = 7;
  logic clk = 0, rst_n = 1;
  logic [N-1:0] pkt_valid = '0, pkt_ready;
  logic [N*COORD_WIDTH-1:0] src_x, src_y, dest_x, dest_y;
  logic [N*VC_ID_WIDTH-1:0] vc_id;
  logic [N*QOS_WIDTH-1:0] qos;
  logic [N*MB*8-1:0] payload_data;
  logic [N*SW-1:0] payload_size;
  logic flit_valid, flit_ready = 0, busy, size_err;
  noc_flit_t flit_out;
  logic [1:0] active_ch;
  logic [31:0] pkts_sent, flits_sent;
  always #5 clk = ~clk;
  nebula_packet_assembler_mc dut (
    .clk(clk), .rst_n(rst_n), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .src_x(src_x), .src_y(src_y), .dest_x(dest_x), .dest_y(dest_y),
    .vc_id(vc_id), .qos(qos), .payload_data(payload_data), .payload_size(payload_size),
    .flit_valid(flit_valid), .flit_out(flit_out), .flit_ready(flit_ready), .busy(busy),
    .active_ch(active_ch), .size_err(size_err), .pkts_sent(pkts_sent), .flits_sent(flits_sent)
  );
  noc_flit_t hdr_c [N];
  logic [7:0] bytes_c [N][MB];
  int size_c [N];
  bit pend [N];
  noc_flit_t exp_q [$];
  int grants [$];
  int seq_m [N];
  int pid_m, pkts_m, flits_m, rr_m, act_m, rdy_mode, cyc;
  logic exp_err;
  int npass = 0, nfail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic offer(input int c, input int size);
    hdr_c[c] = '0;
    hdr_c[c].src_x = 4'($urandom);
    hdr_c[c].src_y = 4'($urandom);
    hdr_c[c].dest_x = 4'($urandom);
    hdr_c[c].dest_y = 4'($urandom);
    hdr_c[c].vc_id = 2'($urandom);
    hdr_c[c].qos = 2'($urandom);
    for (int b = 0; b < MB; b++) bytes_c[c][b] = 8'($urandom);
    size_c[c] = size;
    pend[c] = 1;
  endtask

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      pkt_valid[c] = pend[c];
      src_x[c*4 +: 4] = hdr_c[c].src_x;
      src_y[c*4 +: 4] = hdr_c[c].src_y;
      dest_x[c*4 +: 4] = hdr_c[c].dest_x;
      dest_y[c*4 +: 4] = hdr_c[c].dest_y;
      vc_id[c*2 +: 2] = hdr_c[c].vc_id;
      qos[c*2 +: 2] = hdr_c[c].qos;
      payload_size[c*SW +: SW] = SW'(size_c[c]);
      for (int b = 0; b < MB; b++) payload_data[(c*MB+b)*8 +: 8] = bytes_c[c][b];
    end
    flit_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'(cyc % 3 == 0);
  endtask

  task automatic accept(input int w);
    noc_flit_t f;
    int eff, nf, bi;
    eff = size_c[w] > MB ? MB : size_c[w];
    nf = eff == 0 ? 1 : (eff + 7) / 8;
    exp_err = size_c[w] > MB;
    for (int k = 0; k < nf; k++) begin
      f = hdr_c[w];
      f.seq_num = 8'(seq_m[w]);
      f.packet_id = 8'(pid_m);
      f.flit_type = nf == 1 ? FLIT_TYPE_SINGLE : k == 0 ? FLIT_TYPE_HEAD :
                    k == nf - 1 ? FLIT_TYPE_TAIL : FLIT_TYPE_BODY;
      f.payload = '0;
      for (int b = 0; b < 8; b++) begin
        bi = k * 8 + b;
        if (bi < eff) f.payload[b*8 +: 8] = bytes_c[w][bi];
      end
      exp_q.push_back(f);
    end
    seq_m[w]++;
    pid_m++;
    rr_m = (w + 1) % N;
    pend[w] = 0;
    act_m = w;
    grants.push_back(w);
  endtask

  task automatic cycle();
    int w;
    bit in_flight;
    drive();
    @(negedge clk);
    in_flight = exp_q.size() != 0;
    chk("pkts_sent", pkts_sent, pkts_m);
    chk("flits_sent", flits_sent, flits_m);
    chk("size_err", size_err, exp_err);
    exp_err = 0;
    chk("flit_valid", flit_valid, in_flight);
    chk("busy", busy, in_flight);
    w = -1;
    if (!in_flight)
      for (int i = N - 1; i >= 0; i--) if (pend[(rr_m + i) % N]) w = (rr_m + i) % N;
    chk("pkt_ready", pkt_ready, w < 0 ? 0 : 1 << w);
    if (in_flight) begin
      chk("active_ch", active_ch, act_m);
      chk("flit", flit_out, exp_q[0]);
      if (flit_ready) begin
        void'(exp_q.pop_front());
        flits_m++;
        if (exp_q.size() == 0) pkts_m++;
      end
    end
    if (w >= 0) accept(w);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rst_chk();
    chk("rst_pkt_ready", pkt_ready, 0);
    chk("rst_flit_valid", flit_valid, 0);
    chk("rst_flit_out", flit_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_active_ch", active_ch, 0);
    chk("rst_size_err", size_err, 0);
    chk("rst_pkts_sent", pkts_sent, 0);
    chk("rst_flits_sent", flits_sent, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    rst_chk();
    exp_q.delete();
    grants.delete();
    for (int c = 0; c < N; c++) begin
      pend[c] = 0;
      seq_m[c] = 0;
    end
    pid_m = 0;
    pkts_m = 0;
    flits_m = 0;
    rr_m = 0;
    exp_err = 0;
    repeat (2) @(posedge clk);
    rst_chk();
    #1 rst_n = 1;
  endtask

  task automatic run_idle();
    int n;
    bit any;
    n = 0;
    do begin
      cycle();
      n++;
      any = 0;
      for (int c = 0; c < N; c++) any |= pend[c];
    end while ((exp_q.size() != 0 || any) && n < 3000);
    chk("drain_in_budget", n < 3000, 1);
    cycle();
  endtask

  initial begin
    int code, n;
    bit re, any;
    rdy_mode = 0;
    cyc = 0;
    do_reset();
    // single channel, 3-flit packet with a partial tail
    offer(0, 20);
    run_idle();
    chk("t1_pkts", pkts_sent, 1);
    chk("t1_flits", flits_sent, 3);
    // SINGLE flits, including a zero-size packet
    offer(1, 8);
    run_idle();
    offer(1, 0);
    run_idle();
    // all channels contend; channel 0 re-offers right after its first grant
    do_reset();
    for (int c = 0; c < N; c++) offer(c, 8);
    re = 0;
    n = 0;
    do begin
      cycle();
      n++;
      if (!re && !pend[0]) begin
        offer(0, 8);
        re = 1;
      end
      any = 0;
      for (int c = 0; c < N; c++) any |= pend[c];
    end while ((exp_q.size() != 0 || any) && n < 200);
    cycle();
    code = 0;
    foreach (grants[i]) code = code * 16 + grants[i];
    chk("t3_grant_order", code, 32'h01230);
    chk("t3_grant_count", grants.size(), 5);
    // full-size packet under a 1,0,0 backpressure pattern
    do_reset();
    rdy_mode = 2;
    cyc = 0;
    offer(2, 64);
    run_idle();
    chk("t4_flits", flits_sent, 8);
    // oversize packet is clamped
    rdy_mode = 0;
    offer(3, 65);
    run_idle();
    chk("t5_flits", flits_sent, 16);
    // reset mid-packet, after the BODY flit
    offer(1, 20);
    n = 0;
    while (exp_q.size() != 1 && n < 20) begin
      cycle();
      n++;
    end
    chk("t6_reached_tail", exp_q.size(), 1);
    do_reset();
    offer(0, 8);
    run_idle();
    chk("t6_pkts", pkts_sent, 1);
    // random traffic with random backpressure
    rdy_mode = 1;
    repeat (400) begin
      for (int c = 0; c < N; c++)
        if (!pend[c] && $urandom_range(0, 3) == 0) offer(c, $urandom_range(0, 72));
      cycle();
    end
    run_idle();
    $display("%0d/%0d checks passed", npass, npass + nfail);
    $finish;
  end
endmodule
